key_expand: RTL

KEY_EXPAND -- requirements
Module: key_expand

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/rot_sub_word.sv | 22 ++
 rtl/key_expand.sv | 114 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word/block types, the round-constant
// table and the state encoding used by the key expander.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  // Round constants for rounds 1..10, round 1 in the most significant byte
  localparam logic [8*AES_NR-1:0] RCON_TBL = 80'h01_02_04_08_10_20_40_80_1b_36;

  typedef enum logic [0:0] {
    KE_IDLE   = 1'b0,
    KE_EXPAND = 1'b1
  } ke_state_t;

  // Rcon as a full word (constant in the top byte); rounds outside 1..10 give 0
  function automatic word_t rcon_word(input logic [3:0] rnd);
    rcon_word = '0;
    if (rnd >= 4'd1 && rnd <= 4'(AES_NR))
      rcon_word = {RCON_TBL[8*(AES_NR - int'(rnd)) +: 8], 24'h000000};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in and one byte out, purely combinational.
// The table is packed with entry 0x00 in the most significant byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset 8*(255-a), which is just {~a, 3'b000}
  assign s = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/rot_sub_word.sv
// RotWord followed by SubWord: rotate the word left by one byte, then pass
// each byte through its own S-box.
module rot_sub_word
  import aes_pkg::*;
(
  input  word_t w,
  output word_t sw
);

  word_t rot;

  assign rot = {w[23:0], w[31:24]};

  // One S-box per byte lane
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .s (sw[8*i +: 8])
    );
  end

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion, streaming one round key per accepted handshake.
// Round key 0 is the cipher key itself; each round-key handshake replaces it
// with the next one, computed in a single cycle.
// Optional build macro: KEY_EXPAND_STORE_EN adds an 11-entry round-key store
// with a registered read port (i_rd_idx / o_rd_key).
module key_expand
  import aes_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_key,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  output logic [127:0] o_rkey,
  output logic [3:0]   o_rkey_idx,
  output logic         o_rkey_valid,
  input  logic         i_rkey_ready,
`ifdef KEY_EXPAND_STORE_EN
  input  logic [3:0]   i_rd_idx,
  output logic [127:0] o_rd_key,
`endif
  output logic         o_busy
);

  ke_state_t state;
  logic [3:0] idx;
  block_t     rkey;
  word_t      sw;
  word_t      t;
  word_t      w0n, w1n, w2n, w3n;
  block_t     next_rkey;
  logic       key_hs;
  logic       rkey_hs;
  logic       last_round;

  assign key_hs     = (state == KE_IDLE) && i_key_valid;
  assign rkey_hs    = (state == KE_EXPAND) && i_rkey_ready;
  assign last_round = (idx == 4'(AES_NR));

  rot_sub_word u_rot_sub_word (
    .w  (rkey[31:0]),
    .sw (sw)
  );

  // Next round key from the current one; the Rcon index is the round being produced
  always_comb begin
    t         = sw ^ rcon_word(idx + 4'd1);
    w0n       = rkey[127:96] ^ t;
    w1n       = rkey[95:64]  ^ w0n;
    w2n       = rkey[63:32]  ^ w1n;
    w3n       = rkey[31:0]   ^ w2n;
    next_rkey = {w0n, w1n, w2n, w3n};
  end

  // Control and round-key register: load on key accept, advance on each
  // round-key handshake, return to idle after round 10 is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= KE_IDLE;
      idx   <= '0;
      rkey  <= '0;
    end else begin
      case (state)
        KE_IDLE: begin
          if (key_hs) begin
            rkey  <= i_key;
            idx   <= '0;
            state <= KE_EXPAND;
          end
        end
        KE_EXPAND: begin
          if (rkey_hs) begin
            if (last_round) begin
              state <= KE_IDLE;
            end else begin
              rkey <= next_rkey;
              idx  <= idx + 4'd1;
            end
          end
        end
        default: state <= KE_IDLE;
      endcase
    end
  end

  assign o_key_ready  = (state == KE_IDLE);
  assign o_rkey_valid = (state == KE_EXPAND);
  assign o_busy       = (state == KE_EXPAND);
  assign o_rkey       = rkey;
  assign o_rkey_idx   = idx;

`ifdef KEY_EXPAND_STORE_EN
  block_t store [0:AES_NR];

  // Capture every round key as it is handed to the consumer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= AES_NR; i++) store[i] <= '0;
    end else if (rkey_hs) begin
      store[idx] <= rkey;
    end
  end

  // Registered read; indices past round 10 read as zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rd_key <= '0;
    else if (i_rd_idx <= 4'(AES_NR)) o_rd_key <= store[i_rd_idx];
    else o_rd_key <= '0;
  end
`else
  // Streaming-only build: round keys are visible only on o_rkey as they pass.
`endif

endmodule
